// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_arb_pkg                                                     |
// | Shared types and constants for the FIFO write-port arbiter.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_wr_arbiter_if                                               |
// | Producer, consumer and FIFO-pin bundle around the arbiter.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rd_req;
  logic                    rd_ack;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic [DATA_W-1:0]       fifo_din;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;

  // Producers, consumer and FIFO status as seen from outside the arbiter.
  modport master (
    output req_valid, req_data, rd_req, fifo_full, fifo_empty,
    input  req_ready, rd_ack, fifo_wr, fifo_rd, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, rd_req, fifo_full, fifo_empty,
    output req_ready, rd_ack, fifo_wr, fifo_rd, fifo_din, grant_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                          |
// | Combinational circular first-set search starting at ptr.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            excl_en,
  input  logic [ID_W-1:0] excl_id,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  // One spare bit on the sum keeps the wrap correct for non power-of-two N.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (w_sum >= (ID_W + 1)'(N)) begin
        w_sum = w_sum - (ID_W + 1)'(N);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!any && req[w_cand] && !(excl_en && (w_cand == excl_id))) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_wr_arbiter                                                  |
// | Round-robin, burst-capped sharing of one FIFO write port with    |
// | rd/wr sequencing so a cycle never carries both.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_BURST   = 4,
  parameter int RD_PRIORITY = 1
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int                c_ID_W      = $clog2(N_REQ);
  localparam int                c_BC_W      = $clog2(MAX_BURST + 1);
  localparam logic [c_BC_W-1:0] c_LAST_BEAT = c_BC_W'(MAX_BURST - 1);
  localparam logic [c_ID_W-1:0] c_LAST_ID   = c_ID_W'(N_REQ - 1);
  localparam logic              c_RD_PRIO   = (RD_PRIORITY != 0);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [c_ID_W-1:0] r_owner;
  logic [c_ID_W-1:0] w_owner_nxt;
  logic [c_ID_W-1:0] r_rr_ptr;
  logic [c_ID_W-1:0] w_rr_ptr_nxt;
  logic [c_BC_W-1:0] r_beat_cnt;
  logic [c_BC_W-1:0] w_beat_nxt;
  logic              r_rst_q;

  logic              w_out_en;
  logic              w_owned;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_release;
  logic [c_ID_W-1:0] w_owner_inc;
  logic              w_pick_any;
  logic [c_ID_W-1:0] w_pick_idx;
  logic [N_REQ-1:0]  w_ready;
  logic [DATA_W-1:0] w_lane [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign w_lane[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  // Outputs stay quiet while rst is high and for one cycle after it.
  assign w_out_en    = !rst && !r_rst_q;
  assign w_owned     = (r_state == OWNED);
  assign w_rd_ok     = bus.rd_req && !bus.fifo_empty;
  assign w_wr_ok     = w_owned && bus.req_valid[r_owner] && !bus.fifo_full &&
                       !(c_RD_PRIO && w_rd_ok) && w_out_en;
  assign w_release   = w_owned &&
                       ((w_wr_ok && (r_beat_cnt == c_LAST_BEAT)) || !bus.req_valid[r_owner]);
  assign w_owner_inc = (r_owner == c_LAST_ID) ? '0 : r_owner + c_ID_W'(1);

  // While owned, the pick only matters on release: search past the old owner.
  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (w_owned ? w_owner_inc : r_rr_ptr),
    .excl_en (w_owned),
    .excl_id (r_owner),
    .any     (w_pick_any),
    .idx     (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_beat_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = OWNED;
          w_owner_nxt = w_pick_idx;
          w_beat_nxt  = '0;
        end
      end
      OWNED: begin
        if (w_release) begin
          w_rr_ptr_nxt = w_owner_inc;
          w_beat_nxt   = '0;
          if (w_pick_any) begin
            w_owner_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_wr_ok) begin
          w_beat_nxt = r_beat_cnt + c_BC_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_ready = '0;
    if (w_wr_ok) begin
      w_ready[r_owner] = 1'b1;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.fifo_wr   = w_wr_ok;
  assign bus.fifo_rd   = w_rd_ok && !w_wr_ok && w_out_en;
  assign bus.rd_ack    = bus.fifo_rd;
  assign bus.fifo_din  = w_out_en ? w_lane[r_owner] : '0;
  assign bus.busy      = w_owned && w_out_en;
  assign bus.grant_id  = bus.busy ? r_owner : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_wr_arbiter                                               |
// | Directed scoreboard bench with a behavioural 16-deep FIFO model. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } sb_t;

  logic clk;
  logic rst;
  logic rd_req_v;
  int   n_total;
  int   n_bad;
  int   cyc;
  int   fcount;
  sb_t  sb [$];
  logic [7:0] pq [4][$];

  fifo_wr_arbiter_if #(.N_REQ(4)) bus ();

  fifo_wr_arbiter #(
    .N_REQ       (4),
    .MAX_BURST   (4),
    .RD_PRIORITY (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.rd_req     = rd_req_v;
    bus.fifo_full  = (fcount >= FIFO_DEPTH);
    bus.fifo_empty = (fcount == 0);
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]       = (pq[i].size() != 0);
      bus.req_data[8*i +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
  endtask

  task automatic load(input int p, input int base, input int n, input int n_exp);
    for (int k = 0; k < n; k++) begin
      pq[p].push_back(8'(base + k));
      if (k < n_exp) sb.push_back('{owner: p, data: 8'(base + k)});
    end
  endtask

  // Pattern chars: ! reset, - idle, 0-3 write by owner, a-d owned stall,
  // A-D owned with read issued, R idle with read issued.
  task automatic step(input byte c);
    logic       exp_busy;
    logic       exp_wr;
    logic       exp_rd;
    int         exp_id;
    logic       s_wr;
    logic       s_rd;
    logic [3:0] s_ready;
    sb_t        e;
    rst = (c == "!");
    drive();
    @(negedge clk);
    exp_busy = 1'b0;
    exp_wr   = 1'b0;
    exp_rd   = 1'b0;
    exp_id   = 0;
    if (c >= "0" && c <= "3") begin
      exp_busy = 1'b1; exp_wr = 1'b1; exp_id = int'(c) - int'("0");
    end else if (c >= "a" && c <= "d") begin
      exp_busy = 1'b1; exp_id = int'(c) - int'("a");
    end else if (c >= "A" && c <= "D") begin
      exp_busy = 1'b1; exp_rd = 1'b1; exp_id = int'(c) - int'("A");
    end else if (c == "R") begin
      exp_rd = 1'b1;
    end
    check($sformatf("busy@%0d", cyc), 32'(bus.busy), 32'(exp_busy));
    check($sformatf("fifo_wr@%0d", cyc), 32'(bus.fifo_wr), 32'(exp_wr));
    check($sformatf("fifo_rd@%0d", cyc), 32'(bus.fifo_rd), 32'(exp_rd));
    check($sformatf("rd_ack@%0d", cyc), 32'(bus.rd_ack), 32'(exp_rd));
    check($sformatf("req_ready@%0d", cyc), 32'(bus.req_ready),
          exp_wr ? (32'd1 << exp_id) : 32'd0);
    if (exp_busy || c == "!") begin
      check($sformatf("grant_id@%0d", cyc), 32'(bus.grant_id), 32'(exp_id));
    end
    check($sformatf("wr_and_rd@%0d", cyc), 32'(bus.fifo_wr & bus.fifo_rd), 32'd0);
    check($sformatf("wr_full@%0d", cyc), 32'(bus.fifo_wr & bus.fifo_full), 32'd0);
    check($sformatf("rd_empty@%0d", cyc), 32'(bus.fifo_rd & bus.fifo_empty), 32'd0);
    if (bus.fifo_wr) begin
      check($sformatf("sb_avail@%0d", cyc), 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("din@%0d", cyc), 32'(bus.fifo_din), 32'(e.data));
        check($sformatf("wr_owner@%0d", cyc), 32'(bus.grant_id), 32'(e.owner));
      end
    end
    s_wr    = bus.fifo_wr;
    s_rd    = bus.fifo_rd;
    s_ready = bus.req_ready;
    @(posedge clk);
    #1;
    if (c == "!") begin
      fcount = 0;
    end else begin
      fcount = fcount + int'(s_wr) - int'(s_rd);
    end
    for (int i = 0; i < 4; i++) begin
      if (s_ready[i] && pq[i].size() != 0) void'(pq[i].pop_front());
    end
    cyc++;
  endtask

  task automatic run(input string pat);
    for (int i = 0; i < pat.len(); i++) step(pat[i]);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    cyc      = 0;
    fcount   = 0;
    rst      = 1'b1;
    rd_req_v = 1'b0;

    run("!!");
    // Read request on an empty FIFO right after reset.
    rd_req_v = 1'b1;
    run("--");
    rd_req_v = 1'b0;

    // Single producer, 6 bytes: burst of 4, idle gap, re-grant for the rest.
    load(0, 8'h10, 6, 6);
    run("-0000-00a-");
    rd_req_v = 1'b1;
    run("R");
    rd_req_v = 1'b0;
    run("!");

    // All four producers: back-to-back bursts until the FIFO fills.
    for (int i = 0; i < 4; i++) load(i, 8'h20 + 8*i, 5, 4);
    run("-0000111122223333");
    run("aaaaaaaaaaaaaaaaa");
    rd_req_v = 1'b1;
    run("A");
    rd_req_v = 1'b0;
    sb.push_back('{owner: 0, data: 8'h24});
    run("0ab");
    check("sb_empty_mid", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 4; i++) pq[i].delete();
    rd_req_v = 1'b1;
    run("!");
    rd_req_v = 1'b0;

    // Read interleaved mid-burst, owner drop with wrap, reset mid-burst.
    load(2, 8'h40, 4, 4);
    load(3, 8'h50, 2, 2);
    run("-22");
    rd_req_v = 1'b1;
    run("C");
    rd_req_v = 1'b0;
    run("22");
    load(0, 8'h60, 4, 4);
    run("33d00");
    load(1, 8'h70, 1, 1);
    run("!-00a1b-");
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
